// File: rtl/frame_ctrl.sv
// Purpose: admits one IMG_W x IMG_H frame at a time into the filter datapath and latches filter_sel per frame.
// Latency: first upstream beat accepted two cycles after up_tvalid rises in IDLE; up/dp handshake is combinational in RUN.
// Backpressure: in RUN up_tready follows dp_tready; outside RUN both up_tready and dp_tvalid are held low.
module frame_ctrl #(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       filter_req,
    output logic [3:0]       filter_sel,
    input  logic             up_tvalid,
    input  logic             up_tlast,
    output logic             up_tready,
    output logic             dp_tvalid,
    input  logic             dp_tready,
    input  logic             out_tvalid,
    input  logic             out_tready,
    input  logic             out_tlast,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             err
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int OUT_W = 2 * CNT_W;

    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);
    localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(IMG_W * IMG_H - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] row;
    logic [OUT_W-1:0] out_cnt;
    logic [TMO_W-1:0] tmo;

    logic             up_beat;
    logic             out_beat;
    logic             in_final;
    logic             out_final;

    // Handshake gating: only RUN connects upstream to the datapath.
    always_comb begin
        dp_tvalid = 1'b0;
        up_tready = 1'b0;
        if (state == RUN) begin
            dp_tvalid = up_tvalid;
            up_tready = dp_tready;
        end
    end

    // Beat qualifiers and frame-position decodes.
    always_comb begin
        up_beat   = up_tvalid & up_tready;
        out_beat  = out_tvalid & out_tready;
        in_final  = (col == COL_LAST) && (row == ROW_LAST);
        out_final = (out_cnt == OUT_LAST);
    end

    assign busy = (state != IDLE);

    // Frame sequencer: state, position counters, output monitor, timeout and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            out_cnt    <= '0;
            tmo        <= '0;
            filter_sel <= '0;
            frame_cnt  <= '0;
            err        <= 1'b0;
        end else begin
            // Output-side monitor; an IDLE output beat has no frame to belong to.
            if (out_beat) begin
                if (state == IDLE) begin
                    err <= 1'b1;
                end else begin
                    out_cnt <= out_cnt + 1'b1;
                    if (out_tlast && !out_final) begin
                        err <= 1'b1;
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (up_tvalid) begin
                        filter_sel <= filter_req;
                        col        <= '0;
                        row        <= '0;
                        out_cnt    <= '0;
                        tmo        <= '0;
                        state      <= LOAD;
                    end
                end

                // One settle cycle so filter_sel is stable before the first pixel.
                LOAD: begin
                    state <= RUN;
                end

                // Frame length is fixed by the counters; tlast is only checked.
                RUN: begin
                    if (up_beat) begin
                        if (up_tlast != in_final) begin
                            err <= 1'b1;
                        end
                        if (col == COL_LAST) begin
                            col <= '0;
                            row <= in_final ? '0 : row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                        if (in_final) begin
                            tmo   <= '0;
                            state <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    if (out_beat) begin
                        tmo <= '0;
                        if (out_final) begin
                            if (!out_tlast) begin
                                err <= 1'b1;
                            end
                            frame_cnt <= frame_cnt + 1'b1;
                            state     <= IDLE;
                        end
                    end else if (tmo == TMO_LAST) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_ctrl.sv
// Purpose: directed self-checking bench for frame_ctrl with a 4x2 frame and a 16-cycle drain timeout.
// Latency: inputs driven and outputs sampled 1 time unit after each rising clk edge.
// Backpressure: dp_tready held high; output side driven with out_tready high during beats.
module tb_frame_ctrl;

    localparam int IMG_W   = 4;
    localparam int IMG_H   = 2;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 16;

    logic             clk;
    logic             rst;
    logic [3:0]       filter_req;
    logic [3:0]       filter_sel;
    logic             up_tvalid;
    logic             up_tlast;
    logic             up_tready;
    logic             dp_tvalid;
    logic             dp_tready;
    logic             out_tvalid;
    logic             out_tready;
    logic             out_tlast;
    logic             busy;
    logic [CNT_W-1:0] frame_cnt;
    logic             err;

    int n_chk;
    int n_pass;
    int acc;

    frame_ctrl #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .filter_req(filter_req),
        .filter_sel(filter_sel),
        .up_tvalid (up_tvalid),
        .up_tlast  (up_tlast),
        .up_tready (up_tready),
        .dp_tvalid (dp_tvalid),
        .dp_tready (dp_tready),
        .out_tvalid(out_tvalid),
        .out_tready(out_tready),
        .out_tlast (out_tlast),
        .busy      (busy),
        .frame_cnt (frame_cnt),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts a frame from IDLE and feeds beats for 12 RUN-window cycles.
    // tlast_beat is the 1-based beat index carrying up_tlast; req_mid replaces filter_req mid-frame.
    task automatic run_frame(input logic [3:0] req, input logic [3:0] req_mid,
                             input int tlast_beat, output int accepted);
        accepted   = 0;
        filter_req = req;
        up_tvalid  = 1'b1;
        up_tlast   = 1'b0;
        step();
        chk("load_sel", {28'd0, filter_sel}, {28'd0, req});
        chk("load_rdy", {31'd0, up_tready}, 32'd0);
        step();
        for (int i = 0; i < 12; i++) begin
            if (i == 0) chk("run_dpv", {31'd0, dp_tvalid}, 32'd1);
            if (i == 2) filter_req = req_mid;
            if (i == 5) chk("run_sel", {28'd0, filter_sel}, {28'd0, req});
            up_tlast = (accepted + 1 == tlast_beat);
            if (up_tvalid && up_tready) accepted++;
            step();
        end
        up_tvalid = 1'b0;
        up_tlast  = 1'b0;
        #1;
        chk("drain_rdy", {31'd0, up_tready}, 32'd0);
        chk("drain_busy", {31'd0, busy}, 32'd1);
        chk("drain_sel", {28'd0, filter_sel}, {28'd0, req});
    endtask

    task automatic out_beats(input int n, input int tlast_at);
        for (int i = 0; i < n; i++) begin
            out_tvalid = 1'b1;
            out_tready = 1'b1;
            out_tlast  = (i + 1 == tlast_at);
            step();
        end
        out_tvalid = 1'b0;
        out_tlast  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        n_chk      = 0;
        n_pass     = 0;
        rst        = 1'b1;
        filter_req = 4'd0;
        up_tvalid  = 1'b0;
        up_tlast   = 1'b0;
        dp_tready  = 1'b1;
        out_tvalid = 1'b0;
        out_tready = 1'b0;
        out_tlast  = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rdy", {31'd0, up_tready}, 32'd0);
        chk("rst_dpv", {31'd0, dp_tvalid}, 32'd0);
        chk("rst_sel", {28'd0, filter_sel}, 32'd0);
        chk("rst_fcnt", {16'd0, frame_cnt}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);

        // 1-2: clean frame, then drain with 8 output beats
        run_frame(4'b0011, 4'b0011, 8, acc);
        chk("t1_acc", acc, 8);
        out_beats(8, 8);
        chk("t2_fcnt", {16'd0, frame_cnt}, 32'd1);
        chk("t2_busy", {31'd0, busy}, 32'd0);
        chk("t2_err", {31'd0, err}, 32'd0);

        // 3: filter_req change mid-frame is ignored; next frame latches it
        run_frame(4'b0011, 4'b0010, 8, acc);
        chk("t3a_acc", acc, 8);
        out_beats(8, 8);
        run_frame(4'b0010, 4'b0010, 8, acc);
        out_beats(8, 8);
        chk("t3_fcnt", {16'd0, frame_cnt}, 32'd3);
        chk("t3_err", {31'd0, err}, 32'd0);

        // 4: early tlast on beat 5 -> sticky err, full frame still accepted
        run_frame(4'b0001, 4'b0001, 5, acc);
        chk("t4_acc", acc, 8);
        chk("t4_err", {31'd0, err}, 32'd1);
        out_beats(8, 8);
        chk("t4_fcnt", {16'd0, frame_cnt}, 32'd4);
        run_frame(4'b0100, 4'b0100, 8, acc);
        out_beats(8, 8);
        chk("t4_sticky", {31'd0, err}, 32'd1);
        chk("t4_fcnt2", {16'd0, frame_cnt}, 32'd5);

        // 5: drain timeout after 3 output beats
        do_reset();
        chk("t5_rst_err", {31'd0, err}, 32'd0);
        run_frame(4'b0011, 4'b0011, 8, acc);
        out_beats(3, 0);
        chk("t5_err0", {31'd0, err}, 32'd0);
        for (int i = 0; i < 15; i++) step();
        chk("t5_err15", {31'd0, err}, 32'd0);
        chk("t5_busy15", {31'd0, busy}, 32'd1);
        step();
        chk("t5_err16", {31'd0, err}, 32'd1);
        chk("t5_busy16", {31'd0, busy}, 32'd0);
        chk("t5_fcnt", {16'd0, frame_cnt}, 32'd0);

        // 6: reset mid-RUN after 3 beats, then a clean frame
        do_reset();
        filter_req = 4'b0101;
        up_tvalid  = 1'b1;
        step();
        step();
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1;
        #1;
        chk("t6_rdy", {31'd0, up_tready}, 32'd0);
        chk("t6_dpv", {31'd0, dp_tvalid}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_sel", {28'd0, filter_sel}, 32'd0);
        up_tvalid = 1'b0;
        step();
        rst = 1'b0;
        step();
        run_frame(4'b0101, 4'b0101, 8, acc);
        chk("t6_acc", acc, 8);
        out_beats(8, 8);
        chk("t6_fcnt", {16'd0, frame_cnt}, 32'd1);
        chk("t6_err", {31'd0, err}, 32'd0);
        chk("t6_busy_end", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
